// File: rtl/dfr_input_sequencer.sv
//------------------------------------------------------------------------------
// dfr_input_sequencer
//
// Drives the delay-line reservoir through one input sample. The sample is
// scaled by a per-virtual-node mask coefficient and the reservoir is stepped
// once per virtual node. Each reservoir output is captured and forwarded to
// the readout layer as an indexed node state.
//
// Optional feature (macro DFR_SEQ_TIMEOUT_EN):
//   When defined, a WAIT-cycle counter aborts a node whose reservoir response
//   has not arrived within TIMEOUT_CYCLES cycles. The abort sets the sticky
//   o_err flag and returns the sequencer to IDLE. When undefined, WAIT waits
//   indefinitely and o_err is tied low.
//
// Ports:
//   clk, rst           clock; asynchronous active-high reset
//   i_sample_valid     input sample offered
//   o_sample_ready     high only while idle
//   i_sample_data      unsigned input sample
//   i_mask_we          mask register write strobe (any state)
//   i_mask_addr        mask index; writes at or beyond NUM_VIRTUAL_NODES ignored
//   i_mask_wdata       unsigned mask coefficient (MASK_FRAC fractional bits)
//   o_res_en           one-cycle step request to the reservoir
//   o_res_din          masked sample; held until the next node is loaded
//   i_res_valid        reservoir idle/updated
//   i_res_dout         reservoir output
//   o_state_valid      one-cycle pulse carrying a captured node state
//   o_state_idx        node index of o_state_data
//   o_state_data       captured reservoir output
//   o_sample_done      pulses together with the final node's o_state_valid
//   o_busy             high whenever the sequencer is not idle
//   o_err              sticky timeout flag
//------------------------------------------------------------------------------
module dfr_input_sequencer #(
   parameter int NUM_VIRTUAL_NODES = 10,
   parameter int DATA_WIDTH        = 32,
   parameter int SAMPLE_WIDTH      = 12,
   parameter int MASK_WIDTH        = 8,
   parameter int MASK_FRAC         = 4,
   parameter int TIMEOUT_CYCLES    = 255
) (
   input  logic                                 clk,
   input  logic                                 rst,
   input  logic                                 i_sample_valid,
   output logic                                 o_sample_ready,
   input  logic [SAMPLE_WIDTH-1:0]              i_sample_data,
   input  logic                                 i_mask_we,
   input  logic [$clog2(NUM_VIRTUAL_NODES)-1:0] i_mask_addr,
   input  logic [MASK_WIDTH-1:0]                i_mask_wdata,
   output logic                                 o_res_en,
   output logic [DATA_WIDTH-1:0]                o_res_din,
   input  logic                                 i_res_valid,
   input  logic [DATA_WIDTH-1:0]                i_res_dout,
   output logic                                 o_state_valid,
   output logic [$clog2(NUM_VIRTUAL_NODES)-1:0] o_state_idx,
   output logic [DATA_WIDTH-1:0]                o_state_data,
   output logic                                 o_sample_done,
   output logic                                 o_busy,
   output logic                                 o_err
);

   localparam int IDX_W  = $clog2(NUM_VIRTUAL_NODES);
   localparam int PROD_W = SAMPLE_WIDTH + MASK_WIDTH;

   localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_VIRTUAL_NODES - 1);
   localparam logic [IDX_W:0]   NODES_EXT = (IDX_W + 1)'(NUM_VIRTUAL_NODES);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_DRIVE = 2'd1;
   localparam logic [1:0] S_WAIT  = 2'd2;

   // Unsigned sample * mask, truncated toward zero by the fractional bits.
   function automatic logic [DATA_WIDTH-1:0] f_mask_scale(
      input logic [SAMPLE_WIDTH-1:0] sample,
      input logic [MASK_WIDTH-1:0]   mask
   );
      logic [PROD_W-1:0] prod;
      prod = PROD_W'(sample) * PROD_W'(mask);
      prod = prod >> MASK_FRAC;
      return DATA_WIDTH'(prod);
   endfunction

   logic [1:0]              r_state;
   logic [IDX_W-1:0]        r_idx;
   logic [SAMPLE_WIDTH-1:0] r_sample;
   logic [MASK_WIDTH-1:0]   r_mask [NUM_VIRTUAL_NODES];
   logic                    r_res_en;
   logic [DATA_WIDTH-1:0]   r_res_din;
   logic                    r_state_valid;
   logic [IDX_W-1:0]        r_state_idx;
   logic [DATA_WIDTH-1:0]   r_state_data;
   logic                    r_sample_done;
   logic                    r_busy;

   logic                    w_mask_wr;
   logic                    w_is_last;
   logic [IDX_W-1:0]        w_idx_next;
   logic [IDX_W-1:0]        w_load_idx;
   logic [SAMPLE_WIDTH-1:0] w_load_sample;
   logic [DATA_WIDTH-1:0]   w_load_din;

`ifdef DFR_SEQ_TIMEOUT_EN
   localparam int                WCNT_W    = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [WCNT_W-1:0] WAIT_LAST = WCNT_W'(TIMEOUT_CYCLES - 1);

   logic [WCNT_W-1:0] r_wait_cnt;
   logic              r_err;
`endif

   assign w_mask_wr  = i_mask_we && ({1'b0, i_mask_addr} < NODES_EXT);
   assign w_is_last  = (r_idx == LAST_IDX);
   assign w_idx_next = r_idx + IDX_W'(1);

   // Selects the operands of the next DRIVE load. From IDLE the load uses the
   // incoming sample and node 0; from WAIT it uses the latched sample and the
   // following node. Masks are read before any same-cycle write lands.
   always_comb begin
      if (r_state == S_IDLE) begin
         w_load_sample = i_sample_data;
      end else begin
         w_load_sample = r_sample;
      end
      if ((r_state == S_IDLE) || w_is_last) begin
         w_load_idx = '0;
      end else begin
         w_load_idx = w_idx_next;
      end
      w_load_din = f_mask_scale(w_load_sample, r_mask[w_load_idx]);
   end

   // Mask coefficient bank; writable in every state, cleared by reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int m = 0; m < NUM_VIRTUAL_NODES; m++) begin
            r_mask[m] <= '0;
         end
      end else if (w_mask_wr) begin
         r_mask[i_mask_addr] <= i_mask_wdata;
      end
   end

   // Sequencer FSM with registered reservoir drive and state stream outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state       <= S_IDLE;
         r_idx         <= '0;
         r_sample      <= '0;
         r_res_en      <= 1'b0;
         r_res_din     <= '0;
         r_state_valid <= 1'b0;
         r_state_idx   <= '0;
         r_state_data  <= '0;
         r_sample_done <= 1'b0;
         r_busy        <= 1'b0;
`ifdef DFR_SEQ_TIMEOUT_EN
         r_wait_cnt    <= '0;
         r_err         <= 1'b0;
`endif
      end else begin
         // Pulse outputs default low; only the transitions below raise them.
         r_res_en      <= 1'b0;
         r_state_valid <= 1'b0;
         r_sample_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (i_sample_valid) begin
                  r_sample  <= i_sample_data;
                  r_idx     <= '0;
                  r_res_din <= w_load_din;
                  r_res_en  <= 1'b1;
                  r_busy    <= 1'b1;
                  r_state   <= S_DRIVE;
               end
            end
            S_DRIVE: begin
               r_state <= S_WAIT;
`ifdef DFR_SEQ_TIMEOUT_EN
               r_wait_cnt <= '0;
`endif
            end
            S_WAIT: begin
               if (i_res_valid) begin
                  r_state_data  <= i_res_dout;
                  r_state_idx   <= r_idx;
                  r_state_valid <= 1'b1;
                  if (w_is_last) begin
                     r_sample_done <= 1'b1;
                     r_busy        <= 1'b0;
                     r_state       <= S_IDLE;
                  end else begin
                     // res_din only changes here, at the next node's load.
                     r_idx     <= w_idx_next;
                     r_res_din <= w_load_din;
                     r_res_en  <= 1'b1;
                     r_state   <= S_DRIVE;
                  end
               end
`ifdef DFR_SEQ_TIMEOUT_EN
               else if (r_wait_cnt == WAIT_LAST) begin
                  // Abandon the node silently: no state pulse, no done.
                  r_err   <= 1'b1;
                  r_busy  <= 1'b0;
                  r_state <= S_IDLE;
               end else begin
                  r_wait_cnt <= r_wait_cnt + WCNT_W'(1);
               end
`endif
            end
            default: begin
               r_busy  <= 1'b0;
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign o_sample_ready = ~r_busy;
   assign o_busy         = r_busy;
   assign o_res_en       = r_res_en;
   assign o_res_din      = r_res_din;
   assign o_state_valid  = r_state_valid;
   assign o_state_idx    = r_state_idx;
   assign o_state_data   = r_state_data;
   assign o_sample_done  = r_sample_done;

`ifdef DFR_SEQ_TIMEOUT_EN
   assign o_err = r_err;
`else
   assign o_err = 1'b0;
`endif

endmodule

// File: tb/tb_dfr_input_sequencer.sv
//------------------------------------------------------------------------------
// tb_dfr_input_sequencer
//
// Directed bench for dfr_input_sequencer with default parameters (N = 10,
// 12-bit samples, 8-bit masks with 4 fractional bits). A compliant reservoir
// model answers each res_en two cycles later, optionally stalling one node or
// never answering. Cycle c = 0 is the negedge right after the sample is
// accepted (the DRIVE cycle of node 0); node k is loaded at c = 3k and its
// state pulse is seen at c = 3k + 3 when the reservoir does not stall.
//------------------------------------------------------------------------------
module tb_dfr_input_sequencer;

   localparam int N = 10;

   logic        clk = 1'b0;
   logic        rst;
   logic        i_sample_valid;
   logic        o_sample_ready;
   logic [11:0] i_sample_data;
   logic        i_mask_we;
   logic [3:0]  i_mask_addr;
   logic [7:0]  i_mask_wdata;
   logic        o_res_en;
   logic [31:0] o_res_din;
   logic        i_res_valid;
   logic [31:0] i_res_dout;
   logic        o_state_valid;
   logic [3:0]  o_state_idx;
   logic [31:0] o_state_data;
   logic        o_sample_done;
   logic        o_busy;
   logic        o_err;

   int n_vec = 0;
   int n_err = 0;

   // Reservoir model controls.
   int m_node       = 0;
   int m_stall_node = -1;
   int m_stall_len  = 0;
   bit m_stuck      = 1'b0;
   int m_cnt        = 0;

   dfr_input_sequencer dut (
      .clk            (clk),
      .rst            (rst),
      .i_sample_valid (i_sample_valid),
      .o_sample_ready (o_sample_ready),
      .i_sample_data  (i_sample_data),
      .i_mask_we      (i_mask_we),
      .i_mask_addr    (i_mask_addr),
      .i_mask_wdata   (i_mask_wdata),
      .o_res_en       (o_res_en),
      .o_res_din      (o_res_din),
      .i_res_valid    (i_res_valid),
      .i_res_dout     (i_res_dout),
      .o_state_valid  (o_state_valid),
      .o_state_idx    (o_state_idx),
      .o_state_data   (o_state_data),
      .o_sample_done  (o_sample_done),
      .o_busy         (o_busy),
      .o_err          (o_err)
   );

   always #5 clk = ~clk;

   // Reservoir output delivered for the k-th step of a sample.
   function automatic logic [31:0] res_word(input int k);
      return 32'h5EED_0000 + 32'(k * 273);
   endfunction

   // Reservoir model: res_valid low in the DRIVE cycle and the next one,
   // high in the one after (plus an optional stall on one node).
   initial begin
      i_res_valid = 1'b0;
      i_res_dout  = 32'hDEAD_BEEF;
      forever begin
         @(negedge clk);
         if (rst) begin
            m_cnt       = 0;
            i_res_valid = 1'b0;
         end else if (o_res_en) begin
            m_cnt       = 2 + ((m_node == m_stall_node) ? m_stall_len : 0);
            i_res_valid = 1'b0;
            i_res_dout  = 32'hDEAD_BEEF;
         end else if (m_cnt > 0) begin
            m_cnt = m_cnt - 1;
            if (m_cnt == 0 && !m_stuck) begin
               i_res_valid = 1'b1;
               i_res_dout  = res_word(m_node);
               m_node      = m_node + 1;
            end else begin
               i_res_valid = 1'b0;
            end
         end else begin
            i_res_valid = 1'b0;
            i_res_dout  = 32'hDEAD_BEEF;
         end
      end
   end

   task automatic write_mask(input int a, input int d);
      @(negedge clk);
      i_mask_we    = 1'b1;
      i_mask_addr  = 4'(a);
      i_mask_wdata = 8'(d);
      @(negedge clk);
      i_mask_we    = 1'b0;
   endtask

   // Offers a sample in IDLE; returns at c = 0.
   task automatic start_sample(input logic [11:0] s);
      m_node = 0;
      @(negedge clk);
      i_sample_valid = 1'b1;
      i_sample_data  = s;
      @(negedge clk);
      i_sample_valid = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      @(negedge clk);
      n_vec++; if (o_res_en !== 1'b0)         begin n_err++; $display("FAIL rst_res_en got %b want 0", o_res_en); end
      n_vec++; if (o_res_din !== 32'h0)       begin n_err++; $display("FAIL rst_res_din got %h want 0", o_res_din); end
      n_vec++; if (o_state_valid !== 1'b0)    begin n_err++; $display("FAIL rst_state_valid got %b want 0", o_state_valid); end
      n_vec++; if (o_state_idx !== 4'h0)      begin n_err++; $display("FAIL rst_state_idx got %h want 0", o_state_idx); end
      n_vec++; if (o_state_data !== 32'h0)    begin n_err++; $display("FAIL rst_state_data got %h want 0", o_state_data); end
      n_vec++; if (o_sample_done !== 1'b0)    begin n_err++; $display("FAIL rst_done got %b want 0", o_sample_done); end
      n_vec++; if (o_busy !== 1'b0)           begin n_err++; $display("FAIL rst_busy got %b want 0", o_busy); end
      n_vec++; if (o_sample_ready !== 1'b1)   begin n_err++; $display("FAIL rst_ready got %b want 1", o_sample_ready); end
      n_vec++; if (o_err !== 1'b0)            begin n_err++; $display("FAIL rst_err got %b want 0", o_err); end
      rst = 1'b0;
      @(negedge clk);
   endtask

   // All masks 1.0, sample 0x100: ten steps three cycles apart.
   task automatic test_unity();
      int  n_en;
      logic e;
      n_en = 0;
      for (int a = 0; a < N; a++) write_mask(a, 16);
      start_sample(12'h100);
      for (int c = 0; c <= 30; c++) begin
         if (c > 0) @(negedge clk);
         if (o_res_en === 1'b1) n_en++;
         e = (c % 3 == 0) && (c < 30);
         n_vec++; if (o_res_en !== e)        begin n_err++; $display("FAIL unity_res_en c=%0d got %b want %b", c, o_res_en, e); end
         n_vec++; if (o_res_din !== 32'h100) begin n_err++; $display("FAIL unity_res_din c=%0d got %h want 100", c, o_res_din); end
         e = (c % 3 == 0) && (c > 0);
         n_vec++; if (o_state_valid !== e)   begin n_err++; $display("FAIL unity_state_valid c=%0d got %b want %b", c, o_state_valid, e); end
         if (e) begin
            n_vec++; if (o_state_idx !== 4'(c / 3 - 1))        begin n_err++; $display("FAIL unity_state_idx c=%0d got %0d want %0d", c, o_state_idx, c / 3 - 1); end
            n_vec++; if (o_state_data !== res_word(c / 3 - 1)) begin n_err++; $display("FAIL unity_state_data c=%0d got %h want %h", c, o_state_data, res_word(c / 3 - 1)); end
         end
         e = (c == 30);
         n_vec++; if (o_sample_done !== e)   begin n_err++; $display("FAIL unity_done c=%0d got %b want %b", c, o_sample_done, e); end
         n_vec++; if (o_busy !== !e)         begin n_err++; $display("FAIL unity_busy c=%0d got %b want %b", c, o_busy, !e); end
         n_vec++; if (o_sample_ready !== e)  begin n_err++; $display("FAIL unity_ready c=%0d got %b want %b", c, o_sample_ready, e); end
      end
      n_vec++; if (n_en !== 10) begin n_err++; $display("FAIL unity_res_en_count got %0d want 10", n_en); end
   endtask

   // mask[0] = 2.0, mask[1] = 0.5, sample 0xFFF; the rest stay at 1.0.
   task automatic test_mask_scale();
      logic [31:0] e_din;
      write_mask(0, 32);
      write_mask(1, 8);
      start_sample(12'hFFF);
      for (int c = 0; c <= 30; c++) begin
         if (c > 0) @(negedge clk);
         if (c < 3)      e_din = 32'h1FFE;
         else if (c < 6) e_din = 32'h07FF;
         else            e_din = 32'h0FFF;
         n_vec++; if (o_res_din !== e_din) begin n_err++; $display("FAIL scale_res_din c=%0d got %h want %h", c, o_res_din, e_din); end
         if (c % 3 == 0 && c > 0) begin
            n_vec++; if (o_state_idx !== 4'(c / 3 - 1)) begin n_err++; $display("FAIL scale_state_idx c=%0d got %0d want %0d", c, o_state_idx, c / 3 - 1); end
         end
      end
      n_vec++; if (o_sample_done !== 1'b1) begin n_err++; $display("FAIL scale_done got %b want 1", o_sample_done); end
   endtask

   // Node 3 stalls 20 extra cycles; a competing sample is offered while busy.
   task automatic test_stall_busy();
      int   en_c [N];
      int   sv_c [N];
      int   last;
      logic e_en, e_sv;
      logic [3:0] e_idx;
      write_mask(0, 16);
      write_mask(1, 16);
      for (int k = 0; k < N; k++) begin
         en_c[k] = 3 * k + ((k > 3) ? 20 : 0);
         sv_c[k] = en_c[k] + 3 + ((k == 3) ? 20 : 0);
      end
      last         = sv_c[N-1];
      m_stall_node = 3;
      m_stall_len  = 20;
      start_sample(12'h0AB);
      for (int c = 0; c <= last; c++) begin
         if (c > 0) @(negedge clk);
         e_en = 1'b0; e_sv = 1'b0; e_idx = 4'h0;
         for (int k = 0; k < N; k++) begin
            if (en_c[k] == c) e_en = 1'b1;
            if (sv_c[k] == c) begin e_sv = 1'b1; e_idx = 4'(k); end
         end
         n_vec++; if (o_res_en !== e_en)      begin n_err++; $display("FAIL stall_res_en c=%0d got %b want %b", c, o_res_en, e_en); end
         n_vec++; if (o_res_din !== 32'h0AB)  begin n_err++; $display("FAIL stall_res_din c=%0d got %h want 0ab", c, o_res_din); end
         n_vec++; if (o_state_valid !== e_sv) begin n_err++; $display("FAIL stall_state_valid c=%0d got %b want %b", c, o_state_valid, e_sv); end
         if (e_sv) begin
            n_vec++; if (o_state_idx !== e_idx) begin n_err++; $display("FAIL stall_state_idx c=%0d got %0d want %0d", c, o_state_idx, e_idx); end
         end
         n_vec++; if (o_sample_ready !== (c == last)) begin n_err++; $display("FAIL stall_ready c=%0d got %b want %b", c, o_sample_ready, (c == last)); end
         i_sample_valid = (c <= last - 2);
         i_sample_data  = 12'h555;
      end
      i_sample_valid = 1'b0;
      m_stall_node   = -1;
      m_stall_len    = 0;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         n_vec++; if (o_res_en !== 1'b0) begin n_err++; $display("FAIL busy_sample_consumed c=%0d got %b want 0", c, o_res_en); end
         n_vec++; if (o_busy !== 1'b0)   begin n_err++; $display("FAIL busy_sample_busy c=%0d got %b want 0", c, o_busy); end
      end
   endtask

   // Mask write landing on node 2's load edge uses the old value; the next
   // sample sees the new one. A write to index 15 must be dropped.
   task automatic test_mask_race();
      logic [31:0] e_din;
      for (int p = 0; p < 2; p++) begin
         if (p == 1) write_mask(15, 255);
         start_sample(12'h100);
         for (int c = 0; c <= 30; c++) begin
            if (c > 0) @(negedge clk);
            e_din = 32'h100;
            if (p == 1 && c >= 6 && c < 9) e_din = 32'h300;
            n_vec++; if (o_res_din !== e_din) begin n_err++; $display("FAIL race_res_din p=%0d c=%0d got %h want %h", p, c, o_res_din, e_din); end
            if (p == 0 && c == 5) begin
               i_mask_we    = 1'b1;
               i_mask_addr  = 4'd2;
               i_mask_wdata = 8'd48;
            end else begin
               i_mask_we    = 1'b0;
            end
         end
         n_vec++; if (o_sample_done !== 1'b1) begin n_err++; $display("FAIL race_done p=%0d got %b want 1", p, o_sample_done); end
      end
   endtask

   // Reset while waiting on node 5, then a fresh sample with cleared masks.
   task automatic test_abort();
      start_sample(12'h200);
      for (int c = 1; c <= 16; c++) @(negedge clk);
      n_vec++; if (o_busy !== 1'b1)      begin n_err++; $display("FAIL abort_pre_busy got %b want 1", o_busy); end
      n_vec++; if (o_state_idx !== 4'd4) begin n_err++; $display("FAIL abort_pre_idx got %0d want 4", o_state_idx); end
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      n_vec++; if (o_res_en !== 1'b0)       begin n_err++; $display("FAIL abort_res_en got %b want 0", o_res_en); end
      n_vec++; if (o_res_din !== 32'h0)     begin n_err++; $display("FAIL abort_res_din got %h want 0", o_res_din); end
      n_vec++; if (o_state_valid !== 1'b0)  begin n_err++; $display("FAIL abort_state_valid got %b want 0", o_state_valid); end
      n_vec++; if (o_state_idx !== 4'h0)    begin n_err++; $display("FAIL abort_state_idx got %h want 0", o_state_idx); end
      n_vec++; if (o_state_data !== 32'h0)  begin n_err++; $display("FAIL abort_state_data got %h want 0", o_state_data); end
      n_vec++; if (o_sample_done !== 1'b0)  begin n_err++; $display("FAIL abort_done got %b want 0", o_sample_done); end
      n_vec++; if (o_busy !== 1'b0)         begin n_err++; $display("FAIL abort_busy got %b want 0", o_busy); end
      n_vec++; if (o_sample_ready !== 1'b1) begin n_err++; $display("FAIL abort_ready got %b want 1", o_sample_ready); end
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         n_vec++; if (o_state_valid !== 1'b0 || o_sample_done !== 1'b0) begin n_err++; $display("FAIL abort_late_pulse c=%0d got %b%b want 00", c, o_state_valid, o_sample_done); end
      end
      start_sample(12'h200);
      for (int c = 0; c <= 30; c++) begin
         if (c > 0) @(negedge clk);
         n_vec++; if (o_res_din !== 32'h0) begin n_err++; $display("FAIL abort_restart_din c=%0d got %h want 0", c, o_res_din); end
         if (c % 3 == 0 && c > 0) begin
            n_vec++; if (o_state_idx !== 4'(c / 3 - 1)) begin n_err++; $display("FAIL abort_restart_idx c=%0d got %0d want %0d", c, o_state_idx, c / 3 - 1); end
         end
      end
      n_vec++; if (o_sample_done !== 1'b1) begin n_err++; $display("FAIL abort_restart_done got %b want 1", o_sample_done); end
   endtask

`ifdef DFR_SEQ_TIMEOUT_EN
   // Reservoir never answers: err after 255 WAIT cycles, sticky until rst.
   task automatic test_timeout();
      m_stuck = 1'b1;
      start_sample(12'h010);
      for (int c = 1; c <= 256; c++) begin
         @(negedge clk);
         n_vec++; if (o_state_valid !== 1'b0) begin n_err++; $display("FAIL tmo_state_valid c=%0d got %b want 0", c, o_state_valid); end
         if (c == 255) begin
            n_vec++; if (o_err !== 1'b0)  begin n_err++; $display("FAIL tmo_err_early got %b want 0", o_err); end
            n_vec++; if (o_busy !== 1'b1) begin n_err++; $display("FAIL tmo_busy_early got %b want 1", o_busy); end
         end
      end
      n_vec++; if (o_err !== 1'b1)         begin n_err++; $display("FAIL tmo_err got %b want 1", o_err); end
      n_vec++; if (o_sample_ready !== 1'b1) begin n_err++; $display("FAIL tmo_ready got %b want 1", o_sample_ready); end
      n_vec++; if (o_sample_done !== 1'b0) begin n_err++; $display("FAIL tmo_done got %b want 0", o_sample_done); end
      m_stuck = 1'b0;
      repeat (3) @(negedge clk);
      n_vec++; if (o_err !== 1'b1) begin n_err++; $display("FAIL tmo_err_sticky got %b want 1", o_err); end
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      n_vec++; if (o_err !== 1'b0) begin n_err++; $display("FAIL tmo_err_clear got %b want 0", o_err); end
   endtask
`else
   // Without the timeout feature err stays low.
   task automatic test_err_tied();
      n_vec++; if (o_err !== 1'b0) begin n_err++; $display("FAIL err_tied got %b want 0", o_err); end
   endtask
`endif

   initial begin
      i_sample_valid = 1'b0;
      i_sample_data  = 12'h000;
      i_mask_we      = 1'b0;
      i_mask_addr    = 4'h0;
      i_mask_wdata   = 8'h00;
      test_reset();
      test_unity();
      test_mask_scale();
      test_stall_busy();
      test_mask_race();
      test_abort();
`ifdef DFR_SEQ_TIMEOUT_EN
      test_timeout();
`else
      test_err_tied();
`endif
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   // Global time bound so the run always ends.
   initial begin
      #200000;
      $display("FAIL timeout_guard simulation exceeded time limit");
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err + 1);
      $fatal(1);
   end

endmodule

// File: doc/dfr_input_sequencer.md
Name: dfr_input_sequencer

Overview:
- Initiator/driver for the delay-line reservoir step protocol (res_en / res_din in, res_valid / res_dout out).
- Accepts one input sample, applies a per-virtual-node mask, and steps the reservoir once per virtual node.
- Holds each masked value stable while the reservoir advances, then captures each reservoir output.
- Streams the captured values to the readout layer as indexed node states.

Parameters:
- NUM_VIRTUAL_NODES, 10, masked steps per sample; must match the reservoir.
- DATA_WIDTH, 32, reservoir data width.
- SAMPLE_WIDTH, 12, unsigned input sample width.
- MASK_WIDTH, 8, unsigned mask coefficient width.
- MASK_FRAC, 4, fractional bits in mask; SAMPLE_WIDTH+MASK_WIDTH-MASK_FRAC <= DATA_WIDTH.
- TIMEOUT_CYCLES, 255, WAIT limit (optional feature only).

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- sample_valid  in  1  sample offered
- sample_ready  out  1  high only in IDLE
- sample_data  in  SAMPLE_WIDTH  input sample
- mask_we  in  1  mask register write strobe
- mask_addr  in  $clog2(NUM_VIRTUAL_NODES)  mask index
- mask_wdata  in  MASK_WIDTH  mask value
- res_en  out  1  one-cycle step request to reservoir
- res_din  out  DATA_WIDTH  masked sample to reservoir
- res_valid  in  1  reservoir idle/updated
- res_dout  in  DATA_WIDTH  reservoir output
- state_valid  out  1  one-cycle pulse, captured node state
- state_idx  out  $clog2(NUM_VIRTUAL_NODES)  node index of state_data
- state_data  out  DATA_WIDTH  captured res_dout
- sample_done  out  1  pulse with final node's state_valid
- busy  out  1  high when not IDLE
- err  out  1  sticky timeout flag

Behaviour:
- Reset values:
  - FSM = IDLE; idx = 0; all masks = 0; err = 0.
  - res_din, state_data, state_idx = 0; res_en, state_valid, sample_done = 0; busy = 0; sample_ready = 1.
- Masks: NUM_VIRTUAL_NODES registers, writable in any state.
  - A write to mask_addr >= NUM_VIRTUAL_NODES is ignored.
  - A write takes effect the cycle after mask_we. A DRIVE load in the same cycle uses the old value.
- FSM:
  - IDLE: sample_ready = 1. On sample_valid, latch sample_data, idx = 0, go to DRIVE.
  - DRIVE (1 cycle):
    - On entry, load res_din = zero-extend((sample * mask[idx]) >> MASK_FRAC).
    - res_en = 1 for exactly this cycle. Go to WAIT.
  - WAIT: res_en = 0. On the first cycle with res_valid = 1:
    - Register state_data = res_dout and state_idx = idx.
    - state_valid = 1 in the next cycle.
    - If idx == NUM_VIRTUAL_NODES-1: sample_done = 1 with that state_valid; go to IDLE.
    - Else: idx++ and go to DRIVE.
- res_din must stay constant from DRIVE through all of WAIT. The reservoir sums din combinationally in its update cycle after res_en. res_din changes only at the next DRIVE load.
- Arithmetic: unsigned product of width SAMPLE_WIDTH+MASK_WIDTH, logical right shift by MASK_FRAC, no rounding, no saturation.
- Timing against a compliant reservoir (res_valid low in the DRIVE cycle and the following cycle):
  - 3 cycles per node.
  - Sample accepted at cycle T; first state_valid at T+4.
  - sample_done at T+3N+1; sample_ready high again at T+3N+1.
- state_valid is never asserted outside these pulses. No backpressure on the state stream; the consumer must accept every pulse.
- busy = (FSM != IDLE).
- Reset mid-operation aborts immediately to reset values:
  - Masks are cleared.
  - No state_valid or sample_done is emitted for the aborted sample.
- sample_valid while busy: ignored (sample_ready = 0); the sample is not consumed.

Optional Feature:
- Macro DFR_SEQ_TIMEOUT_EN.
- Defined:
  - A WAIT-cycle counter is cleared on DRIVE.
  - If res_valid has not been seen after TIMEOUT_CYCLES cycles in WAIT: err is set (sticky until rst), FSM returns to IDLE, and no state_valid or sample_done is emitted for that node.
- Undefined: WAIT waits indefinitely; err is tied to 0; no counter logic.

Test Plan:
- Masks all 16 (1.0), sample 0x100, N = 10, reservoir model -> 10 res_en pulses 3 cycles apart; res_din = 0x100 each step; state_idx 0..9; sample_done with idx 9; busy low at T+31.
- mask[0] = 32, mask[1] = 8, sample 0xFFF -> res_din 0x1FFE then 0x7FF; held through WAIT.
- Stalled reservoir holding res_valid low for 20 cycles on node 3 -> res_din held; no state_valid; resume after res_valid; idx continues at 3.
- mask_we to index 2 with value 48 in the same cycle as the DRIVE for idx 2 -> old mask used; the next sample uses 48. mask_addr = 15 write -> ignored.
- rst asserted while in WAIT on node 5 -> all outputs 0 next edge; sample_ready = 1; masks 0; a new sample restarts at idx 0.
- With DFR_SEQ_TIMEOUT_EN, res_valid stuck low -> err = 1 after 255 WAIT cycles; FSM in IDLE; err cleared only by rst.
